ascon_perm_core: RTL and testbench
==================================

ASCON_PERM_CORE -- requirements
Module: ascon_perm_core

Interface
REQ-001 SHALL have parameter UNROLL, default 1, meaning rounds computed per clock; legal values 1, 2, 3, 4, 6.
REQ-002 SHALL have parameter MAX_ROUNDS, default 12, meaning largest accepted round count.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset; asynchronous, active-high.
REQ-005 in_valid_i  input  1  request present.
REQ-006 in_ready_o  output  1  core can accept a request.
REQ-007 state_i  input  state_t (5x64)  permutation input state.
REQ-008 rounds_i  input  4  number of rounds requested (1..MAX_ROUNDS).
REQ-009 out_valid_o  output  1  result present.
REQ-010 out_ready_i  input  1  consumer accepts result.
REQ-011 state_o  output  state_t  permutation result, held stable while out_valid_o=1.
REQ-012 busy_o  output  1  high in states RUN and DONE.
REQ-013 err_o  output  1  single-cycle pulse on rejected request.

Function
REQ-014 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-015 in_ready_o SHALL be 1 only in IDLE.
REQ-016 Accept on in_valid_i & in_ready_o: latch state_i, set round index r = 12 - rounds_i, enter RUN.
REQ-017 rounds_i = 0 or > MAX_ROUNDS: request consumed, err_o pulses next cycle, FSM stays IDLE, state register unchanged.
REQ-018 Each RUN cycle SHALL apply k = min(UNROLL, 12 - r) rounds, constants for indices r..r+k-1, then r += k.
REQ-019 Round constant for index i SHALL be ((15 - i) << 4) | i, XORed into word 2 before the substitution layer.
REQ-020 Round SHALL be: constant addition, 5-bit S-box bitsliced across words, linear layer with rotations (19,28),(61,39),(1,6),(10,17),(7,41) for words 0..4.
REQ-021 When r reaches 12, FSM SHALL enter DONE with out_valid_o=1 the following cycle.
REQ-022 Latency from accept to out_valid_o SHALL be ceil(rounds_i / UNROLL) + 1 cycles (e.g. UNROLL=1, 12 rounds: 13; UNROLL=4, 6 rounds: 3).
REQ-023 DONE SHALL hold out_valid_o and state_o until out_ready_i=1; transfer cycle returns FSM to IDLE.
REQ-024 in_ready_o SHALL NOT assert in the transfer cycle; earliest next accept is one cycle after transfer.
REQ-025 in_valid_i during RUN or DONE SHALL be ignored (no latch, no err_o).
REQ-026 state_o SHALL reflect the internal state register in all states; only meaningful while out_valid_o=1.
REQ-027 out_ready_i high before DONE SHALL have no effect.

Reset
REQ-028 rst_i assertion SHALL immediately force IDLE, state register to 0, r to 0, out_valid_o=0, busy_o=0, err_o=0, in_ready_o=1 after release.
REQ-029 Reset mid-RUN or in DONE SHALL discard the operation without emitting out_valid_o.

Structure
REQ-030 Package ascon_pkg SHALL hold state_t (logic [4:0][63:0]), round-constant function, rotation amounts, and the FSM state enum.
REQ-031 One combinational sub-module ascon_round (state in, round index in, state out) SHALL be instantiated UNROLL times in a chain with per-stage bypass when stage index >= k.
REQ-032 Elaboration SHALL fail for UNROLL outside the legal set or MAX_ROUNDS > 12.

Verification
REQ-033 UNROLL=1, state_i = ASCON-128 IV||key||nonce test vector, rounds_i=12 -> state_o matches reference model after 13 cycles.
REQ-034 UNROLL=4, rounds_i=6, out_ready_i held low 5 cycles -> out_valid_o high from cycle 3, state_o stable until handshake, then in_ready_o returns 1 next cycle.
REQ-035 UNROLL=3, rounds_i=8 -> k sequence 3,3,2, result equals 8-round reference permutation.
REQ-036 rounds_i=0 then rounds_i=13 -> err_o pulses each time, in_ready_o stays 1, no out_valid_o.
REQ-037 rst_i asserted on cycle 4 of a 12-round run -> out_valid_o never asserts, state_o=0, next request completes correctly.
REQ-038 Back-to-back requests with in_valid_i held high -> second accepted one cycle after first output transfer; in_valid_i during RUN produces no err_o.

Source files
------------

// File: rtl/ascon_pkg.sv
// Shared types, constants and helpers for the Ascon permutation core.
package ascon_pkg;

  // Five 64-bit words; index 0 is x0.
  typedef logic [4:0][63:0] state_t;

  localparam int unsigned NumRoundsFull = 12;

  // Linear-layer rotation pairs for words 0..4.
  localparam int unsigned RotA [5] = '{19, 61, 1, 10, 7};
  localparam int unsigned RotB [5] = '{28, 39, 6, 17, 41};

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } fsm_e;

  // Round constant for round index idx: high nibble 15-idx, low nibble idx.
  function automatic logic [7:0] round_const(input logic [3:0] idx);
    logic [3:0] hi;
    hi = 4'hf - idx;
    return {hi, idx};
  endfunction

  // Rotate right; n is always in 1..63 here.
  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition, bitsliced S-box, linear layer.
module ascon_round
  import ascon_pkg::*;
(
  input  state_t     state_i,
  input  logic [3:0] rnd_i,
  output state_t     state_o
);

  state_t x;
  state_t t;

  // Full round computed in place on a working copy.
  always_comb begin
    x = state_i;
    t = '0;
    state_o = '0;
    x[2] = x[2] ^ {56'd0, round_const(rnd_i)};
    // S-box input mixing; x0 uses the x4 value before x4 is updated.
    x[0] = x[0] ^ x[4];
    x[4] = x[4] ^ x[3];
    x[2] = x[2] ^ x[1];
    for (int i = 0; i < 5; i++) begin
      t[i] = ~x[i] & x[(i + 1) % 5];
    end
    for (int i = 0; i < 5; i++) begin
      x[i] = x[i] ^ t[(i + 1) % 5];
    end
    x[1] = x[1] ^ x[0];
    x[0] = x[0] ^ x[4];
    x[3] = x[3] ^ x[2];
    x[2] = ~x[2];
    for (int i = 0; i < 5; i++) begin
      state_o[i] = x[i] ^ ror64(x[i], RotA[i]) ^ ror64(x[i], RotB[i]);
    end
  end

endmodule

// File: rtl/ascon_perm_core.sv
// Iterative Ascon permutation with UNROLL rounds per clock and a valid/ready interface.
module ascon_perm_core
  import ascon_pkg::*;
#(
  parameter int unsigned UNROLL     = 1,
  parameter int unsigned MAX_ROUNDS = 12
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  state_t     state_i,
  input  logic [3:0] rounds_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output state_t     state_o,
  output logic       busy_o,
  output logic       err_o
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 3 || UNROLL == 4 || UNROLL == 6))
  begin : g_bad_unroll
    $error("ascon_perm_core: UNROLL must be one of 1, 2, 3, 4, 6");
  end
  if (MAX_ROUNDS > NumRoundsFull) begin : g_bad_max_rounds
    $error("ascon_perm_core: MAX_ROUNDS must not exceed 12");
  end

  fsm_e       fsm_q, fsm_d;
  state_t     state_q, state_d;
  logic [3:0] r_q, r_d;
  logic       err_q, err_d;

  logic [3:0] remain;
  logic [3:0] k;
  logic       rounds_ok;
  state_t     stage_state [UNROLL+1];

  // Rounds left this cycle: the last step may be shorter than UNROLL.
  always_comb begin
    remain    = 4'd12 - r_q;
    k         = (remain < 4'(UNROLL)) ? remain : 4'(UNROLL);
    rounds_ok = (rounds_i != 4'd0) && (32'(rounds_i) <= MAX_ROUNDS);
  end

  assign stage_state[0] = state_q;

  for (genvar j = 0; j < UNROLL; j++) begin : g_stage
    state_t     rnd_out;
    logic [3:0] rnd_idx;
    // Index may wrap on bypassed stages; their output is discarded.
    assign rnd_idx = r_q + 4'(j);
    ascon_round u_round (
      .state_i (stage_state[j]),
      .rnd_i   (rnd_idx),
      .state_o (rnd_out)
    );
    assign stage_state[j+1] = (4'(j) < k) ? rnd_out : stage_state[j];
  end

  // Next-state logic for the IDLE -> RUN -> DONE handshake.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    r_d     = r_q;
    err_d   = 1'b0;
    unique case (fsm_q)
      StIdle: begin
        if (in_valid_i) begin
          if (rounds_ok) begin
            state_d = state_i;
            r_d     = 4'd12 - rounds_i;
            fsm_d   = StRun;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StRun: begin
        state_d = stage_state[UNROLL];
        r_d     = r_q + k;
        if (r_d == 4'd12) begin
          fsm_d = StDone;
        end
      end
      StDone: begin
        if (out_ready_i) begin
          fsm_d = StIdle;
        end
      end
      default: fsm_d = StIdle;
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fsm_q   <= StIdle;
      state_q <= '0;
      r_q     <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      r_q     <= r_d;
      err_q   <= err_d;
    end
  end

  assign in_ready_o  = (fsm_q == StIdle);
  assign out_valid_o = (fsm_q == StDone);
  assign busy_o      = (fsm_q == StRun) || (fsm_q == StDone);
  assign err_o       = err_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_ascon_perm_core.sv
// Bench for ascon_perm_core: three instances (UNROLL 1, 3, 4) against a table-driven model.
`timescale 1ns/1ps
module tb_ascon_perm_core;
  import ascon_pkg::*;

  localparam int NumDut = 3;
  localparam int UnrollTab [NumDut] = '{1, 3, 4};
  localparam int RotL [5] = '{19, 61, 1, 10, 7};
  localparam int RotR [5] = '{28, 39, 6, 17, 41};
  localparam logic [4:0] SboxTab [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid  [NumDut];
  logic       in_ready  [NumDut];
  state_t     st_in     [NumDut];
  logic [3:0] rnd_in    [NumDut];
  logic       out_valid [NumDut];
  logic       out_ready [NumDut];
  state_t     st_out    [NumDut];
  logic       busy      [NumDut];
  logic       err       [NumDut];

  for (genvar g = 0; g < NumDut; g++) begin : g_dut
    ascon_perm_core #(
      .UNROLL     (UnrollTab[g]),
      .MAX_ROUNDS (12)
    ) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid[g]),
      .in_ready_o  (in_ready[g]),
      .state_i     (st_in[g]),
      .rounds_i    (rnd_in[g]),
      .out_valid_o (out_valid[g]),
      .out_ready_i (out_ready[g]),
      .state_o     (st_out[g]),
      .busy_o      (busy[g]),
      .err_o       (err[g])
    );
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input state_t act, input state_t exp);
    for (int w = 0; w < 5; w++) begin
      check_word($sformatf("%s x%0d", name, w), act[w], exp[w]);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] rc_of(input int i);
    return 8'(240 - 15 * i);
  endfunction

  function automatic logic [63:0] rot(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // S-box applied as a 32-entry table per bit column, x0 as the column MSB.
  function automatic state_t ref_round(input state_t s_in, input int i);
    state_t s, t;
    logic [4:0] col, sub;
    s = s_in;
    t = '0;
    s[2] = s[2] ^ {56'd0, rc_of(i)};
    for (int b = 0; b < 64; b++) begin
      col = {s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]};
      sub = SboxTab[col];
      for (int w = 0; w < 5; w++) t[w][b] = sub[4-w];
    end
    for (int w = 0; w < 5; w++) s[w] = t[w] ^ rot(t[w], RotL[w]) ^ rot(t[w], RotR[w]);
    return s;
  endfunction

  function automatic state_t ref_perm(input state_t s_in, input int rounds);
    state_t s;
    s = s_in;
    for (int i = 12 - rounds; i < 12; i++) s = ref_round(s, i);
    return s;
  endfunction

  function automatic state_t rand_state();
    state_t s;
    for (int w = 0; w < 5; w++) s[w] = {$urandom(), $urandom()};
    return s;
  endfunction

  // Transaction-level expectation per instance: 0 free, 1 computing, 2 presenting.
  int     m_phase [NumDut];
  int     m_left  [NumDut];
  state_t m_res   [NumDut];
  state_t m_reg   [NumDut];
  logic   m_err   [NumDut];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < NumDut; d++) begin
        m_phase[d] <= 0;
        m_left[d]  <= 0;
        m_reg[d]   <= '0;
        m_err[d]   <= 1'b0;
      end
    end else begin
      for (int d = 0; d < NumDut; d++) begin
        m_err[d] <= 1'b0;
        case (m_phase[d])
          0: if (in_valid[d]) begin
            if (rnd_in[d] == 4'd0 || int'(rnd_in[d]) > 12) begin
              m_err[d] <= 1'b1;
            end else begin
              m_res[d]   <= ref_perm(st_in[d], int'(rnd_in[d]));
              m_left[d]  <= (int'(rnd_in[d]) + UnrollTab[d] - 1) / UnrollTab[d];
              m_phase[d] <= 1;
            end
          end
          1: if (m_left[d] == 1) m_phase[d] <= 2;
             else m_left[d] <= m_left[d] - 1;
          default: if (out_ready[d]) begin
            m_phase[d] <= 0;
            m_reg[d]   <= m_res[d];
          end
        endcase
      end
    end
  end

  // Every-cycle comparison of all instances against the model.
  always @(negedge clk) begin
    for (int d = 0; d < NumDut; d++) begin
      check_bit($sformatf("d%0d in_ready", d), in_ready[d], m_phase[d] == 0);
      check_bit($sformatf("d%0d busy", d), busy[d], m_phase[d] != 0);
      check_bit($sformatf("d%0d out_valid", d), out_valid[d], m_phase[d] == 2);
      check_bit($sformatf("d%0d err", d), err[d], m_err[d]);
      if (m_phase[d] == 2) check_state($sformatf("d%0d result", d), st_out[d], m_res[d]);
      else if (m_phase[d] == 0) check_state($sformatf("d%0d idle state", d), st_out[d], m_reg[d]);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic send(input int d, input state_t s, input logic [3:0] n);
    in_valid[d] = 1'b1;
    st_in[d]    = s;
    rnd_in[d]   = n;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (in_ready[d]) begin
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        return;
      end
    end
    in_valid[d] = 1'b0;
    n_checks++;
    n_errors++;
    $display("FAIL d%0d send: in_ready never seen within 50 cycles", d);
  endtask

  task automatic wait_out(input int d, input int bound, output int lat);
    lat = 0;
    while (lat < bound) begin
      @(negedge clk);
      lat++;
      if (out_valid[d]) return;
    end
    n_checks++;
    n_errors++;
    $display("FAIL d%0d wait_out: no out_valid within %0d cycles", d, bound);
    lat = -1;
  endtask

  task automatic run_op(input int d, input state_t s, input int n, input string name);
    int lat;
    send(d, s, 4'(n));
    wait_out(d, 30, lat);
    check_int({name, " latency"}, lat, (n + UnrollTab[d] - 1) / UnrollTab[d] + 1);
    check_state({name, " value"}, st_out[d], ref_perm(s, n));
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    state_t zero_s, iv_s, sa, sb, held, lit;
    int lat;
    int lat_rounds [7] = '{1, 2, 5, 6, 7, 11, 12};
    zero_s = '0;
    for (int d = 0; d < NumDut; d++) begin
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b1;
      st_in[d]     = '0;
      rnd_in[d]    = 4'd0;
    end
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    for (int d = 0; d < NumDut; d++) begin
      check_bit($sformatf("reset d%0d in_ready", d), in_ready[d], 1'b1);
      check_bit($sformatf("reset d%0d out_valid", d), out_valid[d], 1'b0);
      check_bit($sformatf("reset d%0d busy", d), busy[d], 1'b0);
      check_bit($sformatf("reset d%0d err", d), err[d], 1'b0);
      check_word($sformatf("reset d%0d x0", d), st_out[d][0], 64'h0);
    end
    @(posedge clk);
    #1;

    // Hand-worked constants and a one-round result on the zero state.
    check_word("rc 0", {56'd0, rc_of(0)}, 64'hf0);
    check_word("rc 5", {56'd0, rc_of(5)}, 64'ha5);
    check_word("rc 11", {56'd0, rc_of(11)}, 64'h4b);
    lit[0] = 64'h000964B00000004B;
    lit[1] = 64'h0000000096000213;
    lit[2] = 64'h53FFFFFFFFFFFF90;
    lit[3] = 64'h12E580000000004B;
    lit[4] = 64'h0;
    check_state("model 1 round", ref_perm(zero_s, 1), lit);
    send(0, zero_s, 4'd1);
    wait_out(0, 30, lat);
    check_int("u1 1-round latency", lat, 2);
    check_state("u1 1-round literal", st_out[0], lit);
    @(posedge clk);
    #1;

    // Ascon-128 initialisation state, 12 rounds, UNROLL=1.
    iv_s[0] = 64'h80400c0600000000;
    iv_s[1] = 64'h0001020304050607;
    iv_s[2] = 64'h08090a0b0c0d0e0f;
    iv_s[3] = 64'h0001020304050607;
    iv_s[4] = 64'h08090a0b0c0d0e0f;
    send(0, iv_s, 4'd12);
    wait_out(0, 30, lat);
    check_int("u1 12-round latency", lat, 13);
    check_state("u1 ascon128 init", st_out[0], ref_perm(iv_s, 12));
    @(posedge clk);
    #1;

    // UNROLL=4, 6 rounds, consumer stalls for 5 cycles.
    out_ready[2] = 1'b0;
    sa = rand_state();
    send(2, sa, 4'd6);
    wait_out(2, 30, lat);
    check_int("u4 6-round latency", lat, 3);
    held = st_out[2];
    check_state("u4 6-round value", held, ref_perm(sa, 6));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_bit("u4 stall out_valid", out_valid[2], 1'b1);
      check_state("u4 stall hold", st_out[2], held);
    end
    @(posedge clk);
    #1 out_ready[2] = 1'b1;
    @(negedge clk);
    check_bit("u4 transfer in_ready", in_ready[2], 1'b0);
    check_bit("u4 transfer out_valid", out_valid[2], 1'b1);
    @(negedge clk);
    check_bit("u4 after transfer in_ready", in_ready[2], 1'b1);
    check_bit("u4 after transfer out_valid", out_valid[2], 1'b0);
    @(posedge clk);
    #1;

    // UNROLL=3, 8 rounds: steps of 3, 3, 2.
    run_op(1, rand_state(), 8, "u3 8-round");

    // Rejected round counts.
    for (int d = 0; d < NumDut; d++) begin
      for (int v = 0; v < 2; v++) begin
        send(d, rand_state(), (v == 0) ? 4'd0 : 4'd13 + 4'(d));
        @(negedge clk);
        check_bit($sformatf("d%0d reject err", d), err[d], 1'b1);
        check_bit($sformatf("d%0d reject in_ready", d), in_ready[d], 1'b1);
        check_bit($sformatf("d%0d reject out_valid", d), out_valid[d], 1'b0);
        @(negedge clk);
        check_bit($sformatf("d%0d reject err clears", d), err[d], 1'b0);
        @(posedge clk);
        #1;
      end
    end

    // Latency and value across round counts for every instance.
    for (int d = 0; d < NumDut; d++) begin
      foreach (lat_rounds[i]) begin
        run_op(d, rand_state(), lat_rounds[i], $sformatf("d%0d %0d-round", d, lat_rounds[i]));
      end
    end

    // Reset in cycle 4 of a 12-round run discards it.
    send(0, rand_state(), 4'd12);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check_bit("reset-abort out_valid", out_valid[0], 1'b0);
    end
    check_word("reset-abort x0", st_out[0][0], 64'h0);
    check_word("reset-abort x4", st_out[0][4], 64'h0);
    @(posedge clk);
    #1;
    run_op(0, iv_s, 12, "u1 after reset");

    // Back-to-back with in_valid held high on UNROLL=3.
    sa = rand_state();
    sb = rand_state();
    in_valid[1] = 1'b1;
    st_in[1]    = sa;
    rnd_in[1]   = 4'd12;
    @(negedge clk);
    check_bit("b2b first in_ready", in_ready[1], 1'b1);
    @(posedge clk);
    #1 st_in[1] = sb;
    wait_out(1, 30, lat);
    check_int("b2b first latency", lat, 5);
    check_state("b2b first value", st_out[1], ref_perm(sa, 12));
    check_bit("b2b transfer in_ready", in_ready[1], 1'b0);
    @(negedge clk);
    check_bit("b2b next in_ready", in_ready[1], 1'b1);
    @(posedge clk);
    #1 in_valid[1] = 1'b0;
    wait_out(1, 30, lat);
    check_int("b2b second latency", lat, 5);
    check_state("b2b second value", st_out[1], ref_perm(sb, 12));
    @(posedge clk);
    #1;

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
